// File: rtl/nios_setup_v2_sw_pio_if.sv
// Avalon-MM slave bus bundle for the switch/button input PIO.
// The master drives address and strobes; the slave returns registered read data.
interface nios_setup_v2_sw_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_setup_v2_sw_pio.sv
// Input PIO: synchronises and debounces switch/button pins, keeps a sticky W1C
// edge-capture register and raises a maskable level interrupt to the Nios II.
module nios_setup_v2_sw_pio #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    nios_setup_v2_sw_pio_if.slave avs,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);
    localparam int DB    = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam int CNT_W = (DB > 1) ? $clog2(DB) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB - 1);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] rise, fall, edge_set;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;

    assign wr_en = avs.chipselect && !avs.write_n;

    // Per-bit debounce: a bit is accepted only after DB consecutive disagreeing cycles.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                deb_d[i] = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = CNT_W'(cnt_q[i] + 1'b1);
            end
        end
    end

    assign rise = deb_d & ~deb_q;
    assign fall = ~deb_d & deb_q;

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_set = rise;
            1:       edge_set = fall;
            default: edge_set = rise | fall;
        endcase
    end

    // Clear is applied before set so a capture on the clearing edge survives.
    always_comb begin
        edgecap_d = edgecap_q;
        irqmask_d = irqmask_q;
        if (wr_en && avs.address == 2'd3) begin
            edgecap_d = edgecap_q & ~avs.writedata[WIDTH-1:0];
        end
        edgecap_d = edgecap_d | edge_set;
        if (wr_en && avs.address == 2'd2) begin
            irqmask_d = avs.writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        readdata_d = '0;
        case (avs.address)
            2'd0:    readdata_d[WIDTH-1:0] = deb_q;
            2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            edgecap_q  <= '0;
            irqmask_q  <= '0;
            readdata_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q       <= in_port;
            s2_q       <= s1_q;
            deb_q      <= deb_d;
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign avs.readdata = readdata_q;
    assign irq          = |(edgecap_q & irqmask_q);

    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic unused_wdata;
            assign unused_wdata = ^avs.writedata[31:WIDTH];
        end
    endgenerate
endmodule

// File: tb/tb_nios_setup_v2_sw_pio.sv
// Bench for the input PIO: two instances (any-edge and rising-only capture) share
// one stimulus stream and are compared every cycle against a behavioural model.
module tb_nios_setup_v2_sw_pio;
    localparam int W = 10;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_port;
    logic         irq2, irq0;
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    nios_setup_v2_sw_pio_if bus2();
    nios_setup_v2_sw_pio_if bus0();

    nios_setup_v2_sw_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset(reset), .avs(bus2.slave), .in_port(in_port), .irq(irq2)
    );
    nios_setup_v2_sw_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset(reset), .avs(bus0.slave), .in_port(in_port), .irq(irq0)
    );

    // Behavioural model state
    logic [W-1:0] m_pipe[$];
    int           m_run[W];
    logic [W-1:0] m_deb, m_ec2, m_ec0, m_mask;
    logic [31:0]  m_rd2, m_rd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_val(input logic [1:0] a, input logic [W-1:0] ec);
        logic [31:0] v;
        v = '0;
        if (a == 2'd0) v[W-1:0] = m_deb;
        else if (a == 2'd2) v[W-1:0] = m_mask;
        else if (a == 2'd3) v[W-1:0] = ec;
        return v;
    endfunction

    task automatic model_step(input logic r, input logic [W-1:0] pin, input logic [1:0] a,
                              input logic cs, input logic wn, input logic [31:0] wd);
        logic [W-1:0] s2, nd, up, dn, clr;
        if (r) begin
            m_pipe = {};
            m_pipe.push_back('0);
            m_pipe.push_back('0);
            m_deb = '0; m_ec2 = '0; m_ec0 = '0; m_mask = '0;
            m_rd2 = '0; m_rd0 = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
            return;
        end
        m_rd2 = reg_val(a, m_ec2);
        m_rd0 = reg_val(a, m_ec0);
        // value that has crossed both synchroniser stages
        s2 = m_pipe.pop_front();
        m_pipe.push_back(pin);
        nd = m_deb;
        for (int i = 0; i < W; i++) begin
            if (s2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    nd[i]    = s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        up  = nd & ~m_deb;
        dn  = ~nd & m_deb;
        clr = (cs && !wn && a == 2'd3) ? wd[W-1:0] : '0;
        m_ec2 = (m_ec2 & ~clr) | up | dn;
        m_ec0 = (m_ec0 & ~clr) | up;
        if (cs && !wn && a == 2'd2) m_mask = wd[W-1:0];
        m_deb = nd;
    endtask

    task automatic cycle(input logic r, input logic [W-1:0] pin, input logic [1:0] a,
                         input logic cs, input logic wn, input logic [31:0] wd);
        reset = r;
        in_port = pin;
        bus2.address = a; bus2.chipselect = cs; bus2.write_n = wn; bus2.writedata = wd;
        bus0.address = a; bus0.chipselect = cs; bus0.write_n = wn; bus0.writedata = wd;
        model_step(r, pin, a, cs, wn, wd);
        @(posedge clk);
        @(negedge clk);
        chk("rd_any",  bus2.readdata, m_rd2);
        chk("rd_rise", bus0.readdata, m_rd0);
        chk("irq_any",  {31'b0, irq2}, {31'b0, |(m_ec2 & m_mask)});
        chk("irq_rise", {31'b0, irq0}, {31'b0, |(m_ec0 & m_mask)});
    endtask

    task automatic rd(input logic [W-1:0] pin, input logic [1:0] a);
        cycle(1'b0, pin, a, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic wr(input logic [W-1:0] pin, input logic [1:0] a, input logic [31:0] wd);
        cycle(1'b0, pin, a, 1'b1, 1'b0, wd);
    endtask

    initial begin
        logic [W-1:0] pin;
        logic [1:0]   ra;
        @(negedge clk);
        // Reset and idle reads
        for (int i = 0; i < 3; i++) cycle(1'b1, '0, 2'd0, 1'b0, 1'b1, 32'h0);
        for (int a = 0; a < 4; a++) begin
            rd('0, 2'(a));
            chk("rst_read", bus2.readdata, 32'h0);
        end
        chk("rst_irq", {31'b0, irq2}, 32'h0);

        // Single bit rise: edgecap lands at edge k+5, DATA visible from edge k+6
        for (int n = 1; n <= 5; n++) rd(10'h001, 2'd0);
        rd(10'h001, 2'd3);
        chk("ec_early", bus2.readdata, 32'h0);
        rd(10'h001, 2'd0);
        chk("data_rise", bus2.readdata, 32'h1);
        rd(10'h001, 2'd3);
        chk("ec_rise", bus2.readdata, 32'h1);
        chk("irq_unmasked", {31'b0, irq2}, 32'h0);

        // Glitch of 3 cycles is rejected; 4 cycles is accepted
        for (int n = 0; n < 3; n++) rd(10'h009, 2'd0);
        for (int n = 0; n < 10; n++) rd(10'h001, 2'd0);
        chk("glitch_data", bus2.readdata, 32'h1);
        rd(10'h001, 2'd3);
        chk("glitch_ec", bus2.readdata, 32'h1);
        for (int n = 0; n < 4; n++) rd(10'h009, 2'd0);
        for (int n = 0; n < 12; n++) rd(10'h001, 2'd3);
        chk("hold4_ec", bus2.readdata, 32'h9);

        // IRQ flow
        wr(10'h001, 2'd3, 32'h3FF);
        wr(10'h001, 2'd2, 32'h003);
        for (int n = 0; n < 8; n++) rd(10'h003, 2'd0);
        chk("irq_set", {31'b0, irq2}, 32'h1);
        wr(10'h003, 2'd3, 32'h001);
        chk("irq_keep", {31'b0, irq2}, 32'h1);
        wr(10'h003, 2'd3, 32'h002);
        chk("irq_clr", {31'b0, irq2}, 32'h0);
        rd(10'h003, 2'd3);
        chk("ec_clr", bus2.readdata, 32'h0);

        // Set and clear of bit 2 on the same edge
        for (int n = 0; n < 5; n++) rd(10'h007, 2'd0);
        wr(10'h007, 2'd3, 32'h004);
        rd(10'h007, 2'd3);
        chk("setclr_any",  bus2.readdata & 32'h4, 32'h4);
        chk("setclr_rise", bus0.readdata & 32'h4, 32'h4);

        // Rising-only capture versus any-edge capture
        wr(10'h007, 2'd3, 32'h3FF);
        for (int n = 0; n < 10; n++) rd(10'h006, 2'd0);
        rd(10'h006, 2'd3);
        chk("fall_any",  bus2.readdata, 32'h1);
        chk("fall_rise", bus0.readdata, 32'h0);
        wr(10'h006, 2'd3, 32'h3FF);
        for (int n = 0; n < 10; n++) rd(10'h007, 2'd0);
        rd(10'h007, 2'd3);
        chk("rise_any",  bus2.readdata, 32'h1);
        chk("rise_rise", bus0.readdata, 32'h1);

        // Reset in the middle of a debounce count
        wr(10'h007, 2'd3, 32'h3FF);
        for (int n = 0; n < 4; n++) rd(10'h107, 2'd0);
        cycle(1'b1, 10'h107, 2'd0, 1'b0, 1'b1, 32'h0);
        chk("mid_rst_rd2", bus2.readdata, 32'h0);
        chk("mid_rst_rd0", bus0.readdata, 32'h0);
        chk("mid_rst_irq", {31'b0, irq2 | irq0}, 32'h0);
        for (int n = 0; n < 10; n++) rd(10'h007, 2'd0);
        rd(10'h007, 2'd3);
        chk("post_rst_ec", bus2.readdata, 32'h7);

        // Randomised traffic
        pin = 10'h007;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(11) == 0) pin[b] = ~pin[b];
            ra = 2'($urandom_range(3));
            cycle($urandom_range(499) == 0, pin, ra, 1'($urandom_range(1)),
                  $urandom_range(3) != 0, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
